// File: rtl/direct_interc_pipe_pkg.sv
// Shared mode encodings for the pipelined direct interconnect.
package direct_interc_pipe_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_PASS = 2'b00,
    MODE_REG  = 2'b01,
    MODE_ZERO = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

endpackage

// File: rtl/direct_interc_pipe_ch.sv
// One interconnect channel: DEPTH-stage pipeline plus mode-selected output mux.
module direct_interc_pipe_ch
  import direct_interc_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  mode_e            mode_i,
  input  logic             cfg_en_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Stage update: clear on config/ZERO, freeze on HOLD, otherwise shift (PASS keeps it warm).
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (cfg_en_i || (mode_i == MODE_ZERO)) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_d[k] = '0;
      end
    end else if (mode_i != MODE_HOLD) begin
      stage_d[0] = in_i;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // Output mux; configuration isolates the output.
  always_comb begin
    out_o = '0;
    if (!cfg_en_i) begin
      case (mode_i)
        MODE_PASS: out_o = in_i;
        MODE_REG:  out_o = stage_q[DEPTH-1];
        MODE_HOLD: out_o = stage_q[DEPTH-1];
        MODE_ZERO: out_o = '0;
        default:   out_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/direct_interc_pipe.sv
// Multi-channel direct interconnect with per-channel mode loaded by a serial config chain.
module direct_interc_pipe
  import direct_interc_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_en,
  input  logic                    ccff_head,
  output logic                    ccff_tail,
  input  logic [NUM_CH*WIDTH-1:0] in,
  output logic [NUM_CH*WIDTH-1:0] out
);

  localparam int unsigned CFG_W = MODE_W * NUM_CH;

  logic [CFG_W-1:0] mode_q;
  logic [CFG_W-1:0] mode_d;

  // Shift the chain toward the MSB while configuring.
  always_comb begin
    mode_d = mode_q;
    if (cfg_en) begin
      mode_d = {mode_q[CFG_W-2:0], ccff_head};
    end
  end

  // Mode register; reset returns every channel to PASS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= '0;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Tail is the mode register MSB, so each instance adds exactly CFG_W flops to the chain.
  assign ccff_tail = mode_q[CFG_W-1];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    direct_interc_pipe_ch #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .mode_i   (mode_e'(mode_q[c*MODE_W +: MODE_W])),
      .cfg_en_i (cfg_en),
      .in_i     (in[c*WIDTH +: WIDTH]),
      .out_o    (out[c*WIDTH +: WIDTH])
    );
  end

endmodule
